img_row_sequencer: RTL and testbench

Frame-level controller that feeds the image processor's serial input port. It pulls BMP pixel bytes from an upstream byte source and gates each image row on the processor's `rx_ready`. Each byte is serialized MSB-first with an `unproc_clk` strobe, and `valid` frames every row. It sits between the pixel-data fetch logic and `ImageProcTop`'s `data_in`/`unproc_clk`/`valid`/`rx_ready` pins, and replaces the behavioural row driver with synthesizable sequencing.

---
 rtl/img_proc_pkg.sv | 24 ++
 rtl/img_bit_serializer.sv | 54 +++++
 rtl/img_row_sequencer.sv | 134 +++++++++++++
 tb/tb_img_row_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_proc_pkg.sv
// Shared types and constants for the image-processor front end.
// Holds the row-sequencer state enum and the BMP row padding helper.
package img_proc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        LOAD,
        SHIFT,
        PAD_SKIP,
        TAIL,
        GAP
    } img_seq_state_t;

    localparam int DEF_WIDTH  = 200;
    localparam int DEF_HEIGHT = 250;
    localparam int DEF_DEPTH  = 3;

    // BMP rows are padded up to a multiple of four bytes
    function automatic int calc_pad(input int row_bytes);
        return (4 - (row_bytes % 4)) % 4;
    endfunction

endpackage

// File: rtl/img_bit_serializer.sv
// MSB-first byte serializer with a two-cycle strobe per bit.
// unproc_clk idles high; data changes only on the low phase.
module img_bit_serializer (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       unproc_clk,
    output logic       data_out,
    output logic       done
);

    logic [6:0] rest;
    logic [2:0] bit_idx;
    logic       phase;
    logic       active;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rest       <= '0;
            bit_idx    <= '0;
            phase      <= 1'b0;
            active     <= 1'b0;
            unproc_clk <= 1'b1;
            data_out   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                rest       <= byte_in[6:0];
                bit_idx    <= '0;
                phase      <= 1'b0;
                active     <= 1'b1;
                unproc_clk <= 1'b0;
                data_out   <= byte_in[7];
            end else if (active) begin
                if (!phase) begin
                    phase      <= 1'b1;
                    unproc_clk <= 1'b1;
                    done       <= (bit_idx == 3'd7);
                end else if (bit_idx == 3'd7) begin
                    active <= 1'b0;
                end else begin
                    phase      <= 1'b0;
                    unproc_clk <= 1'b0;
                    data_out   <= rest[6];
                    rest       <= {rest[5:0], 1'b0};
                    bit_idx    <= bit_idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/img_row_sequencer.sv
// Frame/row sequencer feeding the image processor serial port.
// Define IMG_SEQ_PAD_STRIP_EN to consume and drop BMP row padding.
module img_row_sequencer
    import img_proc_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [7:0]                    src_byte,
    input  logic                          src_valid,
    output logic                          src_ready,
    input  logic                          rx_ready,
    output logic                          valid,
    output logic                          unproc_clk,
    output logic                          data_out,
    output logic                          busy,
    output logic [$clog2(HEIGHT+1)-1:0]   row_count,
    output logic                          frame_done
);

    localparam int ROW_BYTES = WIDTH * DEPTH;
    localparam int PAD       = calc_pad(ROW_BYTES);
    localparam int BW        = $clog2(ROW_BYTES + 1);
    localparam int RW        = $clog2(HEIGHT + 1);
`ifdef IMG_SEQ_PAD_STRIP_EN
    localparam int SKIP = PAD;
`else
    localparam int SKIP = 0 * PAD;
`endif

    img_seq_state_t state;
    logic [BW-1:0]  byte_cnt;
    logic           armed;
    logic           load;
    logic           ser_done;
`ifdef IMG_SEQ_PAD_STRIP_EN
    logic [1:0]     pad_cnt;
`endif

    assign load = (state == LOAD) && src_valid && src_ready;

    img_bit_serializer u_ser (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .byte_in    (src_byte),
        .unproc_clk (unproc_clk),
        .data_out   (data_out),
        .done       (ser_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            src_ready  <= 1'b0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            row_count  <= '0;
            frame_done <= 1'b0;
            byte_cnt   <= '0;
            armed      <= 1'b0;
`ifdef IMG_SEQ_PAD_STRIP_EN
            pad_cnt    <= '0;
`endif
        end else begin
            // armed masks a start coinciding with reset release
            armed      <= 1'b1;
            frame_done <= 1'b0;
            unique case (state)
                IDLE: if (start && armed) begin
                    busy      <= 1'b1;
                    row_count <= '0;
                    state     <= WAIT_RDY;
                end
                WAIT_RDY: if (rx_ready) begin
                    valid     <= 1'b1;
                    byte_cnt  <= '0;
                    src_ready <= 1'b1;
                    state     <= LOAD;
                end
                LOAD: if (src_valid) begin
                    src_ready <= 1'b0;
                    state     <= SHIFT;
                end
                SHIFT: if (ser_done) begin
                    byte_cnt <= byte_cnt + BW'(1);
                    if (byte_cnt != BW'(ROW_BYTES - 1)) begin
                        src_ready <= 1'b1;
                        state     <= LOAD;
                    end else if (SKIP != 0) begin
                        src_ready <= 1'b1;
                        state     <= PAD_SKIP;
`ifdef IMG_SEQ_PAD_STRIP_EN
                        pad_cnt   <= '0;
`endif
                    end else begin
                        state <= TAIL;
                    end
                end
`ifdef IMG_SEQ_PAD_STRIP_EN
                PAD_SKIP: if (src_valid) begin
                    pad_cnt <= pad_cnt + 2'd1;
                    if (pad_cnt == 2'(PAD - 1)) begin
                        src_ready <= 1'b0;
                        state     <= TAIL;
                    end
                end
`endif
                TAIL: begin
                    valid     <= 1'b0;
                    row_count <= row_count + RW'(1);
                    state     <= GAP;
                end
                GAP: if (row_count == RW'(HEIGHT)) begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end else begin
                    state <= WAIT_RDY;
                end
                default: begin
                    src_ready <= 1'b0;
                    valid     <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img_row_sequencer.sv
// Randomized bench for img_row_sequencer against a byte/bit stream model.
// Expected pad handling follows IMG_SEQ_PAD_STRIP_EN.
module tb_img_row_sequencer;

    localparam int W  = 2;
    localparam int H  = 2;
    localparam int D  = 3;
    localparam int RB = W * D;
`ifdef IMG_SEQ_PAD_STRIP_EN
    localparam int SK = 2;
`else
    localparam int SK = 0;
`endif
    localparam int BASE = H * (3 + 17 * RB + SK);

    logic       clock = 0;
    logic       reset = 1;
    logic       start = 0;
    logic [7:0] src_byte = 0;
    logic       src_valid = 0;
    logic       src_ready;
    logic       rx_ready = 0;
    logic       valid;
    logic       unproc_clk;
    logic       data_out;
    logic       busy;
    logic [1:0] row_count;
    logic       frame_done;

    img_row_sequencer #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .start(start),
        .src_byte(src_byte), .src_valid(src_valid), .src_ready(src_ready),
        .rx_ready(rx_ready), .valid(valid), .unproc_clk(unproc_clk),
        .data_out(data_out), .busy(busy), .row_count(row_count),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    logic [7:0] src_q[$];
    logic [7:0] exp_bytes[$];
    bit         got_bits[$];
    int         rc_log[$];
    bit         pend = 0;
    bit         stall = 0;
    int cyc = 0, rises = 0, vfalls = 0, fdone = 0, strobe_nv = 0;
    int dstab = 0, busy_cyc = 0, first_low = -1, rise8 = -1;
    logic prev_uclk = 1, prev_valid = 0, prev_dout = 0;
    logic [1:0] prev_rc = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // byte source: handshake decided on the values held across the posedge
    always @(negedge clock) begin
        if (pend && src_q.size() > 0) void'(src_q.pop_front());
        src_valid = (src_q.size() > 0) && !stall;
        src_byte  = src_valid ? src_q[0] : 8'h00;
        pend      = src_valid && src_ready && reset;
    end

    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            prev_uclk = 1; prev_valid = 0; prev_dout = 0; prev_rc = 0;
        end else begin
            if (!unproc_clk && first_low < 0) first_low = cyc;
            if (unproc_clk && !prev_uclk) begin
                got_bits.push_back(data_out);
                rises++;
                if (rises == 8) rise8 = cyc;
                if (!valid) strobe_nv++;
            end
            if (unproc_clk && data_out !== prev_dout) dstab++;
            if (prev_valid && !valid) vfalls++;
            if (frame_done) fdone++;
            if (busy) busy_cyc++;
            if (row_count != prev_rc && row_count != 0)
                rc_log.push_back(int'(row_count));
            prev_uclk = unproc_clk; prev_valid = valid;
            prev_dout = data_out; prev_rc = row_count;
        end
    end

    task automatic prep_frame(input bit a5_first);
        logic [7:0] v;
        exp_bytes.delete(); src_q.delete(); got_bits.delete(); rc_log.delete();
        rises = 0; vfalls = 0; fdone = 0; strobe_nv = 0; dstab = 0;
        busy_cyc = 0; first_low = -1; rise8 = -1;
        for (int r = 0; r < H; r++) begin
            for (int b = 0; b < RB; b++) begin
                v = 8'($urandom);
                if (a5_first && r == 0 && b == 0) v = 8'hA5;
                exp_bytes.push_back(v);
                src_q.push_back(v);
            end
            for (int p = 0; p < SK; p++) src_q.push_back(8'($urandom));
        end
    endtask

    task automatic pulse_start;
        @(negedge clock) start = 1;
        @(negedge clock) start = 0;
    endtask

    task automatic wait_done(input string tag);
        bit ok = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clock);
            if (frame_done) ok = 1;
        end
        chk({tag, "_timeout"}, 32'(ok), 1);
        @(negedge clock);
    endtask

    task automatic check_frame(input string tag, input int busy_exp);
        logic [7:0] g;
        chk({tag, "_nbits"}, got_bits.size(), 8 * exp_bytes.size());
        for (int i = 0; i < exp_bytes.size(); i++) begin
            g = 8'h00;
            for (int k = 0; k < 8; k++)
                if (8 * i + k < got_bits.size()) g[7-k] = got_bits[8*i+k];
            chk($sformatf("%s_byte%0d", tag, i), g, exp_bytes[i]);
        end
        chk({tag, "_vfalls"}, vfalls, H);
        chk({tag, "_fdone"}, fdone, 1);
        chk({tag, "_rclen"}, rc_log.size(), 2);
        chk({tag, "_rc0"}, rc_log.size() > 0 ? rc_log[0] : -1, 1);
        chk({tag, "_rc1"}, rc_log.size() > 1 ? rc_log[1] : -1, 2);
        chk({tag, "_strobe_nv"}, strobe_nv, 0);
        chk({tag, "_dstable"}, dstab, 0);
        chk({tag, "_src_left"}, src_q.size(), 0);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_busy_cyc"}, busy_cyc, busy_exp);
    endtask

    initial begin
        bit ok;
        int r0, bad, vh;
        #1 reset = 0;
        #1;
        chk("rst_src_ready", src_ready, 0);
        chk("rst_valid", valid, 0);
        chk("rst_uclk", unproc_clk, 1);
        chk("rst_dout", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rc", row_count, 0);
        chk("rst_fdone", frame_done, 0);
        repeat (3) @(negedge clock);
        reset = 1; start = 1;
        @(negedge clock) start = 0;
        @(negedge clock);
        chk("start_at_release", busy, 0);

        // full frame with 0xA5 leading byte
        prep_frame(1);
        rx_ready = 1;
        pulse_start();
        wait_done("f1");
        check_frame("f1", BASE);
        chk("shape_span", rise8 - first_low + 1, 16);

        // flow control before row 2; rx_ready drops mid row 1
        prep_frame(0);
        pulse_start();
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (valid) ok = 1;
        end
        chk("flow_v1_to", 32'(ok), 1);
        rx_ready = 0;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clock);
            if (row_count == 1) ok = 1;
        end
        chk("flow_row1_to", 32'(ok), 1);
        r0 = rises; vh = 0;
        repeat (50) begin
            @(negedge clock);
            if (valid) vh++;
        end
        chk("flow_valid_low", vh, 0);
        chk("flow_no_strobe", rises - r0, 0);
        rx_ready = 1;
        @(negedge clock);
        chk("flow_resume", valid, 1);
        wait_done("f2");
        check_frame("f2", BASE + 49);

        // source stall in the middle of row 1
        prep_frame(0);
        pulse_start();
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(posedge clock); #1;
            if (src_ready && rises >= 16) ok = 1;
        end
        chk("stall_to", 32'(ok), 1);
        stall = 1;
        r0 = rises; bad = 0;
        repeat (10) begin
            @(negedge clock);
            if (!valid || !unproc_clk) bad++;
        end
        @(posedge clock); #1 stall = 0;
        chk("stall_hold", bad, 0);
        chk("stall_no_strobe", rises - r0, 0);
        wait_done("f3");
        check_frame("f3", BASE + 10);

        // asynchronous reset while shifting
        prep_frame(0);
        pulse_start();
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clock);
            if (rises >= 4 && !unproc_clk) ok = 1;
        end
        chk("mid_to", 32'(ok), 1);
        #2 reset = 0;
        #1;
        chk("mid_src_ready", src_ready, 0);
        chk("mid_valid", valid, 0);
        chk("mid_uclk", unproc_clk, 1);
        chk("mid_dout", data_out, 0);
        chk("mid_busy", busy, 0);
        chk("mid_rc", row_count, 0);
        chk("mid_fdone", frame_done, 0);
        pend = 0;
        src_q.delete();
        repeat (3) @(negedge clock);
        reset = 1;
        repeat (2) @(negedge clock);

        // clean frame after reset, with a start pulse while busy
        prep_frame(0);
        pulse_start();
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clock);
            if (rises >= 20) ok = 1;
        end
        chk("busy_start_to", 32'(ok), 1);
        pulse_start();
        wait_done("f5");
        check_frame("f5", BASE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
